// File: rtl/fft_sequencer_if.sv
// Sample stream bundle between the FFT sequencer and its source/sink.
// master = external producer/consumer, slave = fft_sequencer.
interface fft_sequencer_if #(
    parameter int SAMPLE_W = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_real;
    logic [SAMPLE_W-1:0] in_imag;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_real;
    logic [SAMPLE_W-1:0] out_imag;

    modport master (
        output in_valid,
        output in_real,
        output in_imag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_real,
        input  out_imag
    );

    modport slave (
        input  in_valid,
        input  in_real,
        input  in_imag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_real,
        output out_imag
    );
endinterface

// File: rtl/fft_sequencer.sv
// Control FSM for the in-place radix-2 FFT: loads N samples, sequences
// LOG2N x N/2 butterflies, then drains the RAM in bit-reversed order.
module fft_sequencer #(
    parameter int LOG2N    = 10,
    parameter int SAMPLE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
    fft_sequencer_if.slave      stream,
    input  logic [SAMPLE_W-1:0] ram_a_real,
    input  logic [SAMPLE_W-1:0] ram_a_imag,
    output logic [4:0]          stageCount,
    output logic [LOG2N-2:0]    cycleCount,
    output logic                load,
    output logic                externalLoad,
    output logic                scan,
    output logic [LOG2N-1:0]    externalIndexA,
    output logic [SAMPLE_W-1:0] ext_real,
    output logic [SAMPLE_W-1:0] ext_imag,
    output logic                busy,
    output logic                done
);

    localparam int CW = LOG2N - 1;

    localparam logic [LOG2N-1:0] IDX_ZERO   = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] IDX_ONE    = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-1:0] IDX_LAST   = {LOG2N{1'b1}};
    localparam logic [CW-1:0]    CYC_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]    CYC_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CYC_LAST   = {CW{1'b1}};
    localparam logic [4:0]       STAGE_LAST = 5'(LOG2N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CALC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [LOG2N-1:0] ld_cnt_r;
    logic [LOG2N-1:0] ld_cnt_s;
    logic [LOG2N-1:0] dr_cnt_r;
    logic [LOG2N-1:0] dr_cnt_s;
    logic [4:0]       stage_cnt_r;
    logic [4:0]       stage_cnt_s;
    logic [CW-1:0]    cycle_cnt_r;
    logic [CW-1:0]    cycle_cnt_s;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             load_s;
    logic             ext_load_s;
    logic             scan_s;
    logic [LOG2N-1:0] index_s;
    logic             done_s;

    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] value);
        logic [LOG2N-1:0] result;
        result = IDX_ZERO;
        for (int i = 0; i < LOG2N; i++) begin
            result[i] = value[LOG2N-1-i];
        end
        return result;
    endfunction

    // State and counter registers; rst aborts any transform immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ld_cnt_r    <= IDX_ZERO;
            dr_cnt_r    <= IDX_ZERO;
            stage_cnt_r <= 5'd0;
            cycle_cnt_r <= CYC_ZERO;
        end else begin
            state_r     <= next_state_s;
            ld_cnt_r    <= ld_cnt_s;
            dr_cnt_r    <= dr_cnt_s;
            stage_cnt_r <= stage_cnt_s;
            cycle_cnt_r <= cycle_cnt_s;
        end
    end

    // Next-state, counter advance and RAM control decode.
    always_comb begin
        next_state_s = state_r;
        ld_cnt_s     = ld_cnt_r;
        dr_cnt_s     = dr_cnt_r;
        stage_cnt_s  = stage_cnt_r;
        cycle_cnt_s  = cycle_cnt_r;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        load_s       = 1'b0;
        ext_load_s   = 1'b0;
        scan_s       = 1'b0;
        index_s      = IDX_ZERO;
        done_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end

            LOAD: begin
                in_ready_s = 1'b1;
                ext_load_s = stream.in_valid;
                index_s    = ld_cnt_r;
                if (stream.in_valid) begin
                    if (ld_cnt_r == IDX_LAST) begin
                        ld_cnt_s     = IDX_ZERO;
                        next_state_s = CALC;
                    end else begin
                        ld_cnt_s = ld_cnt_r + IDX_ONE;
                    end
                end else begin
                    ld_cnt_s = ld_cnt_r;
                end
            end

            CALC: begin
                load_s = !hold;
                // Hold freezes both counters so the butterfly address stays put.
                if (!hold) begin
                    if (cycle_cnt_r == CYC_LAST) begin
                        cycle_cnt_s = CYC_ZERO;
                        if (stage_cnt_r == STAGE_LAST) begin
                            stage_cnt_s  = 5'd0;
                            next_state_s = DRAIN;
                        end else begin
                            stage_cnt_s = stage_cnt_r + 5'd1;
                        end
                    end else begin
                        cycle_cnt_s = cycle_cnt_r + CYC_ONE;
                    end
                end else begin
                    cycle_cnt_s = cycle_cnt_r;
                end
            end

            DRAIN: begin
                scan_s      = 1'b1;
                out_valid_s = 1'b1;
                index_s     = bit_reverse(dr_cnt_r);
                if (stream.out_ready) begin
                    if (dr_cnt_r == IDX_LAST) begin
                        dr_cnt_s     = IDX_ZERO;
                        done_s       = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        dr_cnt_s = dr_cnt_r + IDX_ONE;
                    end
                end else begin
                    dr_cnt_s = dr_cnt_r;
                end
            end

            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign stream.in_ready  = in_ready_s;
    assign stream.out_valid = out_valid_s;
    assign stream.out_real  = ram_a_real;
    assign stream.out_imag  = ram_a_imag;

    assign ext_real       = stream.in_real;
    assign ext_imag       = stream.in_imag;
    assign stageCount     = stage_cnt_r;
    assign cycleCount     = cycle_cnt_r;
    assign load           = load_s;
    assign externalLoad   = ext_load_s;
    assign scan           = scan_s;
    assign externalIndexA = index_s;
    assign busy           = (state_r != IDLE);
    assign done           = done_s;

endmodule

// File: tb/tb_fft_sequencer.sv
// Randomized bench for fft_sequencer: RAM stand-in plus a phase/count reference
// model derived from the transform's load/calc/drain rules.
module tb_fft_sequencer;

    localparam int LOG2N    = 10;
    localparam int N        = 1 << LOG2N;
    localparam int HALF     = N / 2;
    localparam int CALC_LEN = LOG2N * HALF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic [31:0] ram_a_real;
    logic [31:0] ram_a_imag;
    logic [4:0]  stageCount;
    logic [8:0]  cycleCount;
    logic        load;
    logic        externalLoad;
    logic        scan;
    logic [9:0]  externalIndexA;
    logic [31:0] ext_real;
    logic [31:0] ext_imag;
    logic        busy;
    logic        done;

    fft_sequencer_if #(.SAMPLE_W(32)) sif ();

    fft_sequencer #(.LOG2N(LOG2N), .SAMPLE_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .hold           (hold),
        .stream         (sif),
        .ram_a_real     (ram_a_real),
        .ram_a_imag     (ram_a_imag),
        .stageCount     (stageCount),
        .cycleCount     (cycleCount),
        .load           (load),
        .externalLoad   (externalLoad),
        .scan           (scan),
        .externalIndexA (externalIndexA),
        .ext_real       (ext_real),
        .ext_imag       (ext_imag),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (((v >> i) & 1) == 1) r += 1 << (LOG2N - 1 - i);
        end
        return r;
    endfunction

    // RAM stand-in: combinational read on port A, written by externalLoad.
    logic [31:0] mem_r [N];
    logic [31:0] mem_i [N];
    assign ram_a_real = mem_r[externalIndexA];
    assign ram_a_imag = mem_i[externalIndexA];

    // Reference model: phase 0 idle, 1 load, 2 calc, 3 drain.
    int          phase, ld, ct, dr;
    logic [31:0] gold_r [N];
    logic [31:0] gold_i [N];
    bit          impulse_mode = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 0; ld <= 0; ct <= 0; dr <= 0;
        end else begin
            if (externalLoad) begin
                mem_r[externalIndexA] <= ext_real;
                mem_i[externalIndexA] <= ext_imag;
            end
            case (phase)
                0: if (start) phase <= 1;
                1: if (sif.in_valid) begin
                    gold_r[ld] <= sif.in_real;
                    gold_i[ld] <= sif.in_imag;
                    if (ld == N - 1) begin ld <= 0; phase <= 2; end
                    else ld <= ld + 1;
                end
                2: if (!hold) begin
                    if (ct == CALC_LEN - 1) begin
                        ct <= 0; phase <= 3;
                        // The spectrum of a unit impulse is flat: stand in for the datapath.
                        if (impulse_mode) begin
                            for (int k = 0; k < N; k++) begin
                                gold_r[k] <= 32'h0001_0000; gold_i[k] <= 32'h0;
                                mem_r[k]  <= 32'h0001_0000; mem_i[k]  <= 32'h0;
                            end
                        end
                    end else ct <= ct + 1;
                end
                default: if (sif.out_ready) begin
                    if (dr == N - 1) begin dr <= 0; phase <= 0; end
                    else dr <= dr + 1;
                end
            endcase
        end
    end

    int writes_total = 0, calc_total = 0, done_total = 0, imp_total = 0;
    int drain_idx [$];

    // Per-cycle comparison against the model, plus event tallies.
    always @(negedge clk) begin
        int e_idx;
        e_idx = (phase == 1) ? ld : (phase == 3) ? brev(dr) : 0;
        chk("busy",      busy,           phase != 0);
        chk("in_ready",  sif.in_ready,   phase == 1);
        chk("ext_load",  externalLoad,   (phase == 1) && sif.in_valid);
        chk("index",     externalIndexA, e_idx);
        chk("load",      load,           (phase == 2) && !hold);
        chk("stage",     stageCount,     (phase == 2) ? ct / HALF : 0);
        chk("cycle",     cycleCount,     (phase == 2) ? ct % HALF : 0);
        chk("scan",      scan,           phase == 3);
        chk("out_valid", sif.out_valid,  phase == 3);
        chk("done",      done,           (phase == 3) && sif.out_ready && (dr == N - 1));
        chk("ext_real",  ext_real,       sif.in_real);
        chk("ext_imag",  ext_imag,       sif.in_imag);
        if (phase == 3) begin
            chk("out_real", sif.out_real, gold_r[brev(dr)]);
            chk("out_imag", sif.out_imag, gold_i[brev(dr)]);
        end
        if (externalLoad) writes_total++;
        if (busy && !sif.in_ready && !sif.out_valid) calc_total++;
        if (done) done_total++;
        if (sif.out_valid && sif.out_ready) begin
            drain_idx.push_back(int'(externalIndexA));
            if (sif.out_real == 32'h0001_0000 && sif.out_imag == 32'h0) imp_total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_load(input bit gaps, input bit impulse, input int count);
        int k = 0, guard = 0;
        bit hs;
        while (k < count && guard < 20000) begin
            sif.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sif.in_real  = impulse ? ((k == 0) ? 32'h0001_0000 : 32'h0) : $urandom();
            sif.in_imag  = impulse ? 32'h0 : $urandom();
            if (gaps) begin
                hold  = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end
            hs = sif.in_valid && sif.in_ready;
            tick();
            guard++;
            if (hs) k++;
        end
        sif.in_valid = 1'b0; hold = 1'b0; start = 1'b0;
        chk("load_bound", guard < 20000, 1);
    endtask

    task automatic do_calc(input int mode, output int held);
        int guard = 0;
        held = 0;
        while (busy && !sif.in_ready && !sif.out_valid && guard < 20000) begin
            case (mode)
                1:       hold = (held < 7 && stageCount == 5'd3 && cycleCount == 9'd100);
                2:       hold = ($urandom_range(0, 9) == 0);
                default: hold = 1'b0;
            endcase
            if (hold) held++;
            tick();
            guard++;
        end
        hold = 1'b0;
        chk("calc_bound", guard < 20000, 1);
    endtask

    task automatic do_drain(input bit rnd, input int max_hs);
        int guard = 0, hs = 0;
        while (sif.out_valid && hs < max_hs && guard < 20000) begin
            sif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) hold = 1'($urandom_range(0, 1));
            if (sif.out_ready) hs++;
            tick();
            guard++;
        end
        sif.out_ready = 1'b0; hold = 1'b0;
        chk("drain_bound", guard < 20000, 1);
    endtask

    task automatic full_run(input bit gaps, input bit impulse, input int hold_mode,
                            input bit rnd_ready, output int calc_cycles);
        int w0, c0, d0, i0, q0, held;
        impulse_mode = impulse;
        w0 = writes_total; c0 = calc_total; d0 = done_total; i0 = imp_total;
        q0 = drain_idx.size();
        begin_run();
        do_load(gaps, impulse, N);
        do_calc(hold_mode, held);
        do_drain(rnd_ready, N);
        tick();
        calc_cycles = calc_total - c0;
        chk("writes",      writes_total - w0, N);
        chk("calc_cycles", calc_cycles, CALC_LEN + held);
        chk("done_pulses", done_total - d0, 1);
        chk("drain_count", drain_idx.size() - q0, N);
        if (drain_idx.size() >= q0 + 4) begin
            chk("drain_idx0", drain_idx[q0],     0);
            chk("drain_idx1", drain_idx[q0 + 1], 512);
            chk("drain_idx2", drain_idx[q0 + 2], 256);
            chk("drain_idx3", drain_idx[q0 + 3], 768);
        end
        if (impulse) chk("impulse_outputs", imp_total - i0, N);
        chk("idle_after", busy, 0);
    endtask

    task automatic rst_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_busy"},      busy,           0);
        chk({tag, "_in_ready"},  sif.in_ready,   0);
        chk({tag, "_out_valid"}, sif.out_valid,  0);
        chk({tag, "_ext_load"},  externalLoad,   0);
        chk({tag, "_load"},      load,           0);
        chk({tag, "_scan"},      scan,           0);
        chk({tag, "_index"},     externalIndexA, 0);
        chk({tag, "_stage"},     stageCount,     0);
        chk({tag, "_cycle"},     cycleCount,     0);
        chk({tag, "_done"},      done,           0);
        sif.in_valid = 1'b0; sif.out_ready = 1'b0; hold = 1'b0; start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int calc_a, calc_b, calc_c;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        sif.in_valid = 1'b0; sif.in_real = 32'h0; sif.in_imag = 32'h0;
        sif.out_ready = 1'b0;
        #3;
        chk("por_busy",      busy,           0);
        chk("por_in_ready",  sif.in_ready,   0);
        chk("por_out_valid", sif.out_valid,  0);
        chk("por_load",      load,           0);
        chk("por_index",     externalIndexA, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Impulse, back-to-back load, unheld calc, consumer always ready.
        full_run(1'b0, 1'b1, 0, 1'b0, calc_a);
        chk("calc_len_unheld", calc_a, 5120);

        // Gappy load, 7-cycle hold in stage 3, stalling consumer.
        full_run(1'b1, 1'b0, 1, 1'b1, calc_b);
        chk("calc_len_held7", calc_b, 5127);

        // Reset mid-LOAD, mid-CALC and mid-DRAIN.
        impulse_mode = 1'b0;
        begin_run();
        do_load(1'b1, 1'b0, 300);
        sif.in_valid = 1'b1;
        rst_check("rst_load");
        begin_run();
        do_load(1'b0, 1'b0, N);
        repeat (1000) tick();
        hold = 1'b1;
        rst_check("rst_calc");
        begin_run();
        do_load(1'b0, 1'b0, N);
        do_calc(0, calc_c);
        do_drain(1'b1, 100);
        sif.out_ready = 1'b1;
        rst_check("rst_drain");

        // Fully randomized transform with random holds.
        full_run(1'b1, 1'b0, 2, 1'b1, calc_c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
